mem_req_arbiter: RTL

MEM_REQ_ARBITER -- requirements
Module: mem_req_arbiter

---
 rtl/mem_req_arbiter_pkg.sv | 17 +
 rtl/mem_req_arbiter_owner_fifo.sv | 72 +++++++
 rtl/mem_req_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg
//   Shared definitions for the instruction/data memory request arbiter:
//   owner encodings carried through the in-order response FIFO and the
//   grant FSM state encoding.
package mem_req_arbiter_pkg;

  // Owner bit stored per outstanding transaction.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // IDLE: no grant held. LOCK: grant held until the memory accepts it.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// arb_owner_fifo
//   In-order FIFO of owner bits, one entry per accepted memory request that
//   still awaits its response. Push is ignored when full and pop is ignored
//   when empty, so the caller's accounting can never corrupt the pointers.
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   push, push_owner   append an owner bit
//   pop                drop the head entry
//   full, empty        occupancy flags (registered)
//   head               owner bit at the head
//   count              current number of entries
module arb_owner_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter  int MAX_OUTST = 2,
  localparam int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             push_owner,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             owners [MAX_OUTST];
  logic             push_ok;
  logic             pop_ok;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(MAX_OUTST - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full    = (cnt == CNT_W'(MAX_OUTST));
  assign empty   = (cnt == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = owners[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_ok)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_ok) owners[wr_ptr] <= push_owner;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
//   Shares one memory request port between an instruction-fetch requester
//   and a load/store requester. A grant made while the memory is not ready
//   is locked until accepted. Accepted requests record their owner in an
//   in-order FIFO so responses are routed back to the right requester.
//   Default arbitration is fixed data-over-inst priority; defining the macro
//   MEM_ARB_RR_EN selects round-robin on simultaneous requests.
// Ports:
//   clk, resetn                         clock, asynchronous active-low reset
//   inst_req/inst_addr                  fetch request
//   inst_addr_ok/inst_data_ok/inst_rdata  fetch accept / response / data
//   data_req/wr/wstrb/addr/wdata        load/store request
//   data_addr_ok/data_data_ok/data_rdata  data accept / response / data
//   mem_req/wr/wstrb/addr/wdata         shared memory request
//   mem_addr_ok/mem_data_ok/mem_rdata   memory accept / response / data
//   arb_err                             sticky: response with nothing outstanding
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  arb_state_e       state;
  arb_state_e       state_nxt;
  logic             lock_owner;
  logic             lock_owner_nxt;
  logic             pick_owner;
  logic             gnt_valid;
  logic             gnt_owner;
  logic             issue_ok;
  logic             handshake;
  logic             rsp_valid;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  logic [CNT_W-1:0] fifo_count;

  // Registered occupancy: a pop in the same cycle does not reopen the port.
  assign issue_ok = !fifo_full && (fifo_count < CNT_W'(MAX_OUTST));

`ifdef MEM_ARB_RR_EN
  logic last_owner;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        last_owner <= OWN_INST;
    else if (handshake) last_owner <= gnt_owner;
  end

  always_comb begin
    pick_owner = OWN_INST;
    if (data_req && inst_req) pick_owner = ~last_owner;
    else if (data_req)        pick_owner = OWN_DATA;
  end
`else
  assign pick_owner = data_req ? OWN_DATA : OWN_INST;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      lock_owner <= OWN_INST;
    end else begin
      state      <= state_nxt;
      lock_owner <= lock_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    lock_owner_nxt = lock_owner;
    gnt_valid      = 1'b0;
    gnt_owner      = OWN_INST;
    case (state)
      IDLE: begin
        if (issue_ok && (data_req || inst_req)) begin
          gnt_valid = 1'b1;
          gnt_owner = pick_owner;
          if (!mem_addr_ok) begin
            state_nxt      = LOCK;
            lock_owner_nxt = pick_owner;
          end
        end
      end
      LOCK: begin
        // The held owner keeps the port regardless of the other requester.
        gnt_valid = issue_ok;
        gnt_owner = lock_owner;
        if (gnt_valid && mem_addr_ok) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by resetn so nothing leaks while reset is asserted.
  assign mem_req   = resetn && gnt_valid;
  assign handshake = mem_req && mem_addr_ok;

  assign mem_wr    = (gnt_owner == OWN_DATA) && data_wr;
  assign mem_wstrb = (gnt_owner == OWN_DATA) ? data_wstrb : 4'h0;
  assign mem_addr  = (gnt_owner == OWN_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (gnt_owner == OWN_DATA) ? data_wdata : 32'h0;

  assign inst_addr_ok = handshake && (gnt_owner == OWN_INST);
  assign data_addr_ok = handshake && (gnt_owner == OWN_DATA);

  assign rsp_valid    = resetn && mem_data_ok && !fifo_empty;
  assign inst_data_ok = rsp_valid && (fifo_head == OWN_INST);
  assign data_data_ok = rsp_valid && (fifo_head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                        arb_err <= 1'b0;
    else if (mem_data_ok && fifo_empty) arb_err <= 1'b1;
  end

  arb_owner_fifo #(
    .MAX_OUTST (MAX_OUTST)
  ) u_owner_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (handshake),
    .push_owner (gnt_owner),
    .pop        (rsp_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .count      (fifo_count)
  );

endmodule
